vga_fb_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 12 +
 rtl/vga_wr_fifo.sv | 50 +++++
 rtl/vga_fb_arbiter.sv | 119 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter slice.
package vga_pkg;

    localparam int          PIX_W = 24;
    localparam logic [23:0] BLACK = 24'h0;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO that holds posted CPU pixel writes until a blanking slot frees the RAM.
module vga_wr_fifo #(
    parameter int depth = 4,
    parameter int width = 38
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic [cw-1:0]    count;

    assign full  = (count == cw'(depth));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge pclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, clear engine and posted
// CPU writes use the blanking slots.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int h_size     = 100,
    parameter int v_size     = 100,
    parameter int fifo_depth = 4,
    localparam int fb_aw = $clog2(h_size * v_size),
    localparam int hw    = $clog2(h_size),
    localparam int vw    = $clog2(v_size)
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             valid,
    input  logic [hw-1:0]    h_addr,
    input  logic [vw-1:0]    v_addr,
    output logic [PIX_W-1:0] vga_data,
    input  logic             cpu_wvalid,
    output logic             cpu_wready,
    input  logic [fb_aw-1:0] cpu_waddr,
    input  logic [PIX_W-1:0] cpu_wdata,
    input  logic             clr_start,
    input  logic [PIX_W-1:0] clr_color,
    output logic             clr_busy,
    output logic             mem_en,
    output logic             mem_we,
    output logic [fb_aw-1:0] mem_addr,
    output logic [PIX_W-1:0] mem_wdata,
    input  logic [PIX_W-1:0] mem_rdata
);

    localparam logic [fb_aw-1:0] last_addr = fb_aw'(h_size * v_size - 1);

    clr_state_t       state_q, state_d;
    logic [fb_aw-1:0] clr_cnt_q, clr_cnt_d;
    logic [PIX_W-1:0] clr_color_q, clr_color_d;
    logic             rd_pend_q;
    logic             rd_slot;

    logic [fb_aw-1:0] disp_addr;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [fb_aw+PIX_W-1:0] fifo_head;

    assign disp_addr = fb_aw'(v_addr) * fb_aw'(h_size) + fb_aw'(h_addr);

    assign cpu_wready = ~fifo_full;
    assign fifo_push  = cpu_wvalid & cpu_wready;
    assign clr_busy   = (state_q == CLEAR);
    assign vga_data   = rd_pend_q ? mem_rdata : BLACK;

    vga_wr_fifo #(
        .depth (fifo_depth),
        .width (fb_aw + PIX_W)
    ) u_wr_fifo (
        .pclk  (pclk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({cpu_waddr, cpu_wdata}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            clr_color_q <= BLACK;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            rd_pend_q   <= rd_slot;
        end
    end

    // Fixed-priority slot choice; clr_start is applied last so it restarts even mid-clear.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        rd_slot     = 1'b0;
        fifo_pop    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = disp_addr;
        mem_wdata   = clr_color_q;

        if (valid) begin
            rd_slot = 1'b1;
            mem_en  = 1'b1;
        end else if (state_q == CLEAR) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = clr_cnt_q;
            if (clr_cnt_q == last_addr) begin
                state_d = IDLE;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end else if (!fifo_empty) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fifo_head[fb_aw+PIX_W-1:PIX_W];
            mem_wdata = fifo_head[PIX_W-1:0];
            fifo_pop  = 1'b1;
        end

        if (clr_start) begin
            state_d     = CLEAR;
            clr_cnt_d   = '0;
            clr_color_d = clr_color;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural framebuffer RAM.
module tb_vga_fb_arbiter;

    localparam int FB_AW = 14;
    localparam int HW    = 7;
    localparam int VW    = 7;

    logic             pclk = 1'b0;
    logic             reset;
    logic             valid;
    logic [HW-1:0]    h_addr;
    logic [VW-1:0]    v_addr;
    logic [23:0]      vga_data;
    logic             cpu_wvalid;
    logic             cpu_wready;
    logic [FB_AW-1:0] cpu_waddr;
    logic [23:0]      cpu_wdata;
    logic             clr_start;
    logic [23:0]      clr_color;
    logic             clr_busy;
    logic             mem_en;
    logic             mem_we;
    logic [FB_AW-1:0] mem_addr;
    logic [23:0]      mem_wdata;
    logic [23:0]      mem_rdata;

    logic [23:0] ram [16384];
    logic [FB_AW-1:0] wr_addr_q [$];
    logic [23:0]      wr_data_q [$];

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    vga_fb_arbiter #(
        .h_size     (100),
        .v_size     (100),
        .fifo_depth (4)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .valid      (valid),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .vga_data   (vga_data),
        .cpu_wvalid (cpu_wvalid),
        .cpu_wready (cpu_wready),
        .cpu_waddr  (cpu_waddr),
        .cpu_wdata  (cpu_wdata),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // RAM model with one-cycle read latency; every write is also logged in order.
    always @(posedge pclk) begin
        if (mem_en && !mem_we) begin
            mem_rdata <= ram[mem_addr];
        end
        if (mem_en && mem_we) begin
            ram[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic start_clear(input logic [23:0] color);
        clr_color = color;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b0; h_addr = '0; v_addr = '0;
        cpu_wvalid = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        clr_start = 1'b0; clr_color = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (vga_data !== 24'h0) begin errors++; $display("[TB] FAIL reset_vga_data got %h want 000000", vga_data); end
        checks++;
        if (clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr_busy got %b want 0", clr_busy); end
        checks++;
        if (cpu_wready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_wready got %b want 1", cpu_wready); end
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en got %b want 0", mem_en); end
    endtask

    task automatic test_display_read();
        ram[203] = 24'hABCDEF;
        valid = 1'b1; h_addr = 7'd3; v_addr = 7'd2;
        #1;
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL disp_read_strobe got en=%b we=%b want en=1 we=0", mem_en, mem_we); end
        checks++;
        if (mem_addr !== 14'd203) begin errors++; $display("[TB] FAIL disp_addr got %0d want 203", mem_addr); end
        step();
        valid = 1'b0;
        #1;
        checks++;
        if (vga_data !== 24'hABCDEF) begin errors++; $display("[TB] FAIL disp_data got %h want abcdef", vga_data); end
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL disp_idle_en got %b want 0", mem_en); end
        step();
        checks++;
        if (vga_data !== 24'h0) begin errors++; $display("[TB] FAIL disp_blank_data got %h want 000000", vga_data); end
    endtask

    task automatic test_fifo_drain();
        wr_addr_q.delete(); wr_data_q.delete();
        valid = 1'b1; h_addr = '0; v_addr = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cpu_wready !== 1'b1) begin errors++; $display("[TB] FAIL fifo_ready_%0d got %b want 1", i, cpu_wready); end
            cpu_wvalid = 1'b1;
            cpu_waddr  = 14'(10 + i);
            cpu_wdata  = 24'hC0DE00 + 24'(i);
            step();
        end
        cpu_wvalid = 1'b0;
        #1;
        checks++;
        if (cpu_wready !== 1'b0) begin errors++; $display("[TB] FAIL fifo_full_ready got %b want 0", cpu_wready); end
        checks++;
        if (wr_addr_q.size() != 0) begin errors++; $display("[TB] FAIL fifo_no_write_during_active got %0d writes want 0", wr_addr_q.size()); end
        valid = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 14'd10) begin errors++; $display("[TB] FAIL fifo_first_slot got we=%b addr=%0d want we=1 addr=10", mem_we, mem_addr); end
        step();
        checks++;
        if (cpu_wready !== 1'b1) begin errors++; $display("[TB] FAIL fifo_ready_after_pop got %b want 1", cpu_wready); end
        repeat (4) step();
        checks++;
        if (wr_addr_q.size() != 4) begin
            errors++; $display("[TB] FAIL fifo_drain_count got %0d want 4", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr_q[i] !== 14'(10 + i) || wr_data_q[i] !== 24'hC0DE00 + 24'(i))
                begin
                    errors++;
                    $display("[TB] FAIL fifo_order_%0d got addr=%0d data=%h want addr=%0d data=%h",
                             i, wr_addr_q[i], wr_data_q[i], 10 + i, 24'hC0DE00 + 24'(i));
                end
            end
        end
    endtask

    task automatic test_clear_full();
        int cyc = 0;
        int bad = 0;
        wr_addr_q.delete(); wr_data_q.delete();
        valid = 1'b0;
        start_clear(24'h00FF00);
        while (clr_busy === 1'b1 && cyc < 20000) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != 10000) begin errors++; $display("[TB] FAIL clear_busy_cycles got %0d want 10000", cyc); end
        checks++;
        if (wr_addr_q.size() != 10000) begin errors++; $display("[TB] FAIL clear_write_count got %0d want 10000", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 10000; i++) begin
            if (wr_addr_q[i] !== 14'(i) || wr_data_q[i] !== 24'h00FF00) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL clear_sequence got %0d bad writes want 0", bad); end
    endtask

    task automatic test_clear_cpu_override();
        int cyc = 0;
        wr_addr_q.delete(); wr_data_q.delete();
        start_clear(24'h0000FF);
        step();
        checks++;
        if (cpu_wready !== 1'b1) begin errors++; $display("[TB] FAIL override_ready got %b want 1", cpu_wready); end
        cpu_wvalid = 1'b1; cpu_waddr = 14'd5; cpu_wdata = 24'h123456;
        step();
        cpu_wvalid = 1'b0;
        while (clr_busy === 1'b1 && cyc < 20000) begin
            step();
            cyc++;
        end
        step();
        step();
        checks++;
        if (ram[5] !== 24'h123456) begin errors++; $display("[TB] FAIL override_ram5 got %h want 123456", ram[5]); end
        checks++;
        if (wr_addr_q.size() != 10001) begin
            errors++; $display("[TB] FAIL override_write_count got %0d want 10001", wr_addr_q.size());
        end else if (wr_addr_q[10000] !== 14'd5 || wr_data_q[10000] !== 24'h123456) begin
            errors++; $display("[TB] FAIL override_last_write got addr=%0d data=%h want addr=5 data=123456",
                               wr_addr_q[10000], wr_data_q[10000]);
        end
    endtask

    task automatic test_clear_restart();
        start_clear(24'h0000FF);
        repeat (500) step();
        checks++;
        if (mem_addr !== 14'd500) begin errors++; $display("[TB] FAIL restart_cnt got %0d want 500", mem_addr); end
        clr_color = 24'hFF0000;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 14'd0 || mem_wdata !== 24'hFF0000) begin
            errors++; $display("[TB] FAIL restart_write got we=%b addr=%0d data=%h want we=1 addr=0 data=ff0000",
                               mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset_midclear();
        cpu_wvalid = 1'b1; cpu_waddr = 14'd20; cpu_wdata = 24'h111111;
        step();
        cpu_waddr = 14'd21; cpu_wdata = 24'h222222;
        step();
        cpu_wvalid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_clr_busy got %b want 0", clr_busy); end
        checks++;
        if (cpu_wready !== 1'b1) begin errors++; $display("[TB] FAIL abort_cpu_wready got %b want 1", cpu_wready); end
        wr_addr_q.delete(); wr_data_q.delete();
        repeat (5) step();
        checks++;
        if (wr_addr_q.size() != 0) begin errors++; $display("[TB] FAIL abort_writes got %0d want 0", wr_addr_q.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_display_read();
        test_fifo_drain();
        test_clear_full();
        test_clear_cpu_override();
        test_clear_restart();
        test_reset_midclear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
